// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// uart_tx_ctrl : UART frame sequencer (start, LSB-first data, optional parity,
// stop) feeding the registered TX output mux.  Rev 1.0
// ============================================================================
module uart_tx_ctrl #(
   parameter int BUS_WIDTH = 8
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic [BUS_WIDTH-1:0] P_DATA,
   input  logic                 DATA_VALID,
   input  logic                 PAR_EN,
   input  logic                 PAR_TYP,
   output logic [1:0]           mux_sel,
   output logic                 SER_DATA,
   output logic                 PAR_BIT,
   output logic                 busy
);

   localparam int CNT_W = (BUS_WIDTH > 1) ? $clog2(BUS_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUS_WIDTH - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_e;

   state_e                 state_q;
   logic [CNT_W-1:0]       cnt_q;
   logic [BUS_WIDTH-1:0]   data_q;
   logic                   par_en_q;
   logic                   par_typ_q;
   logic                   w_accept;

   // A new word is taken only when no frame body is in flight; STOP still completes its cycle.
   assign w_accept = DATA_VALID && ((state_q == S_IDLE) || (state_q == S_STOP));

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
      end else begin
         if (w_accept) begin
            data_q    <= P_DATA;
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
         end
         case (state_q)
            S_IDLE: begin
               if (w_accept) state_q <= S_START;
            end
            S_START: begin
               state_q <= S_DATA;
               cnt_q   <= '0;
            end
            S_DATA: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= par_en_q ? S_PARITY : S_STOP;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_PARITY: begin
               state_q <= S_STOP;
            end
            S_STOP: begin
               state_q <= w_accept ? S_START : S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   always_comb begin
      mux_sel = 2'b01;
      case (state_q)
         S_START:  mux_sel = 2'b00;
         S_DATA:   mux_sel = 2'b10;
         S_PARITY: mux_sel = 2'b11;
         default:  mux_sel = 2'b01;
      endcase
   end

   assign SER_DATA = (state_q == S_DATA) ? data_q[cnt_q] : 1'b0;
   assign PAR_BIT  = (^data_q) ^ par_typ_q;
   assign busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ============================================================================
// tb_uart_tx_ctrl : directed, table-driven bench for uart_tx_ctrl.  Rev 1.0
// ============================================================================
module tb_uart_tx_ctrl;

   logic       CLK;
   logic       RST;
   logic [7:0] P_DATA;
   logic       DATA_VALID;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic [1:0] mux_sel;
   logic       SER_DATA;
   logic       PAR_BIT;
   logic       busy;

   int n_tests = 0;
   int n_fail  = 0;

   uart_tx_ctrl #(.BUS_WIDTH(8)) dut (
      .CLK        (CLK),
      .RST        (RST),
      .P_DATA     (P_DATA),
      .DATA_VALID (DATA_VALID),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .mux_sel    (mux_sel),
      .SER_DATA   (SER_DATA),
      .PAR_BIT    (PAR_BIT),
      .busy       (busy)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   typedef struct {
      logic [7:0] d;
      logic       pe;
      logic       pt;
      logic       ep;   // hand-computed expected parity bit
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " mux_sel"},  {14'd0, mux_sel}, 16'h1);
      chk({tag, " busy"},     {15'd0, busy},    16'h0);
      chk({tag, " SER_DATA"}, {15'd0, SER_DATA},16'h0);
      chk({tag, " PAR_BIT"},  {15'd0, PAR_BIT}, 16'h0);
   endtask

   // Sends one frame and checks every cycle until two cycles past STOP.
   // pulse_at >= 0 injects a stray DATA_VALID with 8'hFF during that cycle.
   task automatic frame(input logic [7:0] d, input logic pe, input logic pt,
                        input logic ep, input int pulse_at, input string tag);
      int len;
      int busy_cnt;
      logic [1:0] e_mux;
      logic       e_ser;
      len      = pe ? 11 : 10;
      busy_cnt = 0;
      @(negedge CLK);
      P_DATA = d; PAR_EN = pe; PAR_TYP = pt; DATA_VALID = 1'b1;
      for (int c = 0; c < len + 2; c++) begin
         @(negedge CLK);
         DATA_VALID = 1'b0;
         if (busy) busy_cnt++;
         e_ser = 1'b0;
         if (c == 0)                  e_mux = 2'b00;
         else if (c <= 8) begin       e_mux = 2'b10; e_ser = d[c-1]; end
         else if (pe && c == 9)       e_mux = 2'b11;
         else                         e_mux = 2'b01;
         chk($sformatf("%s c%0d mux_sel", tag, c), {14'd0, mux_sel}, {14'd0, e_mux});
         chk($sformatf("%s c%0d SER_DATA", tag, c), {15'd0, SER_DATA}, {15'd0, e_ser});
         if (pe && c == 9)
            chk($sformatf("%s PAR_BIT", tag), {15'd0, PAR_BIT}, {15'd0, ep});
         if (c == pulse_at) begin
            DATA_VALID = 1'b1;
            P_DATA     = 8'hFF;
         end
      end
      chk({tag, " busy cycles"}, busy_cnt[15:0], len[15:0]);
   endtask

   initial begin
      vecs[0] = '{d: 8'hA5, pe: 1'b0, pt: 1'b0, ep: 1'b0};
      vecs[1] = '{d: 8'hA5, pe: 1'b1, pt: 1'b0, ep: 1'b0};
      vecs[2] = '{d: 8'hA5, pe: 1'b1, pt: 1'b1, ep: 1'b1};
      vecs[3] = '{d: 8'h07, pe: 1'b1, pt: 1'b0, ep: 1'b1};
      vecs[4] = '{d: 8'h07, pe: 1'b1, pt: 1'b1, ep: 1'b0};
      vecs[5] = '{d: 8'h80, pe: 1'b1, pt: 1'b0, ep: 1'b1};
      vecs[6] = '{d: 8'h6E, pe: 1'b0, pt: 1'b1, ep: 1'b0};

      // Reset held with a pending request
      RST = 1'b0; DATA_VALID = 1'b1; P_DATA = 8'hFF; PAR_EN = 1'b1; PAR_TYP = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         chk_reset_outputs($sformatf("reset%0d", i));
      end
      DATA_VALID = 1'b0;
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk_reset_outputs("idle");

      for (int v = 0; v < 7; v++)
         frame(vecs[v].d, vecs[v].pe, vecs[v].pt, vecs[v].ep, -1, $sformatf("vec%0d", v));

      // Stray request in DATA cycle 3 must be ignored
      frame(8'h3C, 1'b0, 1'b0, 1'b0, 3, "ignore");

      // Back-to-back: request held, second word presented during STOP
      @(negedge CLK);
      P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      for (int c = 0; c < 21; c++) begin
         logic [1:0] e_mux;
         logic       e_ser;
         logic [7:0] w;
         @(negedge CLK);
         if (c == 10) DATA_VALID = 1'b0;
         w     = (c < 10) ? 8'h01 : 8'h80;
         e_ser = 1'b0;
         if (c == 0 || c == 10)                      e_mux = 2'b00;
         else if ((c >= 1 && c <= 8) || (c >= 11 && c <= 18)) begin
            e_mux = 2'b10;
            e_ser = w[(c < 10) ? c - 1 : c - 11];
         end else                                    e_mux = 2'b01;
         chk($sformatf("b2b c%0d mux_sel", c), {14'd0, mux_sel}, {14'd0, e_mux});
         chk($sformatf("b2b c%0d SER_DATA", c), {15'd0, SER_DATA}, {15'd0, e_ser});
         chk($sformatf("b2b c%0d busy", c), {15'd0, busy}, (c == 20) ? 16'h0 : 16'h1);
         if (c == 9) P_DATA = 8'h80;
      end

      // Reset in DATA cycle 4 of 8'hF0 (odd parity selected so PAR_BIT was 1)
      @(negedge CLK);
      P_DATA = 8'hF0; PAR_EN = 1'b1; PAR_TYP = 1'b1; DATA_VALID = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge CLK);
         DATA_VALID = 1'b0;
      end
      chk("pre-reset mux_sel", {14'd0, mux_sel}, 16'h2);
      chk("pre-reset PAR_BIT", {15'd0, PAR_BIT}, 16'h1);
      #2 RST = 1'b0;
      #1 chk_reset_outputs("midreset");
      @(negedge CLK);
      chk_reset_outputs("midreset hold");
      RST = 1'b1;
      @(negedge CLK);
      chk_reset_outputs("after release");
      frame(8'h0F, 1'b1, 1'b0, 1'b0, -1, "post-reset");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
